mod_addsub_ctrl: RTL and testbench

- Initiator-side sequencer for the multi-precision adder's start/subtract/shift/done interface.
- Performs modular add/sub for the RSA datapath: A+B mod M and A−B mod M.
- Each operation issues one or two adder operations and applies a conditional correction step.
- Sits between the Montgomery/exponentiation control and the shared adder instance.

---
 rtl/mod_addsub_ctrl_if.sv | 28 ++
 rtl/mod_addsub_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_mod_addsub_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_addsub_ctrl_if.sv
// Adder-side bus of the modular add/sub sequencer: the sequencer is the master, the
// shared multi-precision adder is the slave.
interface mod_addsub_ctrl_if #(
  parameter int WIDTH = 514
);
  // Handshake: the master holds adder_a/adder_b/adder_subtract stable and pulses
  // adder_start for one cycle. The slave must drop adder_done within one cycle of
  // adder_start, then raise it with adder_result valid. adder_done may stay high
  // until the next adder_start. adder_shift is a one-cycle request that halves
  // adder_result in place.
  logic             adder_start;
  logic             adder_subtract;
  logic             adder_shift;
  logic [WIDTH-1:0] adder_a;
  logic [WIDTH-1:0] adder_b;
  logic [WIDTH:0]   adder_result;
  logic             adder_done;

  modport master (
    output adder_start, adder_subtract, adder_shift, adder_a, adder_b,
    input  adder_result, adder_done
  );

  modport slave (
    input  adder_start, adder_subtract, adder_shift, adder_a, adder_b,
    output adder_result, adder_done
  );
endinterface

// File: rtl/mod_addsub_ctrl.sv
// Modular add/sub sequencer driving a shared multi-precision adder: A+B mod M, A-B mod M.
// Define MOD_HALVE_EN to add op=10 (A/2 mod M); otherwise op=10 is reported as illegal.
module mod_addsub_ctrl #(
  parameter int WIDTH = 514
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       dbg_state,
  mod_addsub_ctrl_if.master adder
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE1 = 3'd1,
    S_WAIT1  = 3'd2,
    S_ISSUE2 = 3'd3,
    S_WAIT2  = 3'd4,
`ifdef MOD_HALVE_EN
    S_SHIFT  = 3'd5,
    S_CAPT   = 3'd6,
`endif
    S_FIN    = 3'd7
  } state_t;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_HALVE = 2'b10;

  function automatic logic op_legal(input logic [1:0] o);
`ifdef MOD_HALVE_EN
    return o != 2'b11;
`else
    return (o != 2'b11) && (o != 2'b10);
`endif
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] r1_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] adder_a_q;
  logic [WIDTH-1:0] adder_b_q;
  logic             sub_q;
  logic             first_q;
  logic             error_q;
  logic             adder_start_c;
  logic             adder_shift_c;
  logic             done_ok;
  logic             borrow;

  // The adder may still show the previous op's done in the first wait cycle.
  assign done_ok = adder.adder_done && !first_q;
  assign borrow  = adder.adder_result[WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_ISSUE1;
      S_ISSUE1: state_d = op_legal(op_q) ? S_WAIT1 : S_FIN;
      S_WAIT1: begin
        if (done_ok) begin
          case (op_q)
            OP_ADD:   state_d = S_ISSUE2;
            OP_SUB:   state_d = borrow ? S_ISSUE2 : S_FIN;
`ifdef MOD_HALVE_EN
            OP_HALVE: state_d = S_SHIFT;
`endif
            default:  state_d = S_FIN;
          endcase
        end
      end
      S_ISSUE2: state_d = S_WAIT2;
      S_WAIT2:  if (done_ok) state_d = S_FIN;
`ifdef MOD_HALVE_EN
      S_SHIFT:  state_d = S_CAPT;
      S_CAPT:   state_d = S_FIN;
`endif
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    adder_start_c = 1'b0;
    adder_shift_c = 1'b0;
    case (state_q)
      S_IDLE: ;
      S_FIN:  done = 1'b1;
      S_ISSUE1: begin
        busy          = 1'b1;
        adder_start_c = op_legal(op_q);
      end
      S_ISSUE2: begin
        busy          = 1'b1;
        adder_start_c = 1'b1;
      end
`ifdef MOD_HALVE_EN
      S_SHIFT: begin
        busy          = 1'b1;
        adder_shift_c = 1'b1;
      end
`endif
      default: busy = 1'b1;
    endcase
    error = done && error_q;
  end

  // Operand capture and result update; adder operands are loaded one cycle ahead of
  // their ISSUE cycle so they are stable when adder_start is seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= '0;
      m_q       <= '0;
      r1_q      <= '0;
      result_q  <= '0;
      adder_a_q <= '0;
      adder_b_q <= '0;
      sub_q     <= 1'b0;
      first_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      first_q <= (state_q == S_ISSUE1) || (state_q == S_ISSUE2);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q    <= op;
            m_q     <= in_m;
            error_q <= 1'b0;
            if (op_legal(op)) begin
              adder_a_q <= in_a;
              adder_b_q <= (op == OP_HALVE) ? (in_a[0] ? in_m : '0) : in_b;
              sub_q     <= (op == OP_SUB);
            end
          end
        end
        S_ISSUE1: begin
          if (!op_legal(op_q)) begin
            error_q  <= 1'b1;
            result_q <= '0;
          end
        end
        S_WAIT1: begin
          if (done_ok) begin
            r1_q <= adder.adder_result[WIDTH-1:0];
            if ((op_q == OP_ADD) || ((op_q == OP_SUB) && borrow)) begin
              adder_a_q <= adder.adder_result[WIDTH-1:0];
              adder_b_q <= m_q;
              sub_q     <= (op_q == OP_ADD);
            end else if (op_q == OP_SUB) begin
              result_q <= adder.adder_result[WIDTH-1:0];
            end
          end
        end
        S_WAIT2: begin
          if (done_ok) begin
            // A negative R1-M means R1 was already reduced.
            result_q <= ((op_q == OP_ADD) && borrow) ? r1_q : adder.adder_result[WIDTH-1:0];
          end
        end
`ifdef MOD_HALVE_EN
        S_CAPT: result_q <= adder.adder_result[WIDTH-1:0];
`endif
        default: ;
      endcase
    end
  end

  assign result               = result_q;
  assign dbg_state            = state_q;
  assign adder.adder_start    = adder_start_c;
  assign adder.adder_shift    = adder_shift_c;
  assign adder.adder_subtract = sub_q;
  assign adder.adder_a        = adder_a_q;
  assign adder.adder_b        = adder_b_q;

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Bench for mod_addsub_ctrl: behavioural adder model, directed and random modular ops
// checked against a plain-arithmetic reference. Honours MOD_HALVE_EN.
module tb_mod_addsub_ctrl;
  localparam int W = 514;
`ifdef MOD_HALVE_EN
  localparam bit HALVE = 1'b1;
`else
  localparam bit HALVE = 1'b0;
`endif

  logic         clk, rst, start;
  logic [1:0]   op;
  logic [W-1:0] in_a, in_b, in_m, result;
  logic         busy, done, error;
  logic [2:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;
  int n_shift  = 0;
  int n_done   = 0;
  int lat_cfg  = 3;
  bit lazy_cfg = 1'b0;
  logic [W-1:0] exp_q[$];

  mod_addsub_ctrl_if #(.WIDTH(W)) aif();

  mod_addsub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(rst), .start(start), .op(op),
    .in_a(in_a), .in_b(in_b), .in_m(in_m),
    .busy(busy), .done(done), .error(error), .result(result),
    .dbg_state(dbg_state), .adder(aif)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // ---------------- adder model ----------------
  // lazy_cfg keeps a stale done high through the first cycle after start.
  logic [W:0] pend;
  int         cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aif.adder_done   <= 1'b0;
      aif.adder_result <= '0;
      pend             <= '0;
      cnt              <= 0;
    end else if (aif.adder_start) begin
      pend <= aif.adder_subtract ? ({1'b0, aif.adder_a} - {1'b0, aif.adder_b})
                                 : ({1'b0, aif.adder_a} + {1'b0, aif.adder_b});
      cnt  <= lat_cfg;
      if (!lazy_cfg) aif.adder_done <= 1'b0;
    end else if (aif.adder_shift) begin
      aif.adder_result <= aif.adder_result >> 1;
    end else if (cnt > 1) begin
      cnt            <= cnt - 1;
      aif.adder_done <= 1'b0;
    end else if (cnt == 1) begin
      cnt              <= 0;
      aif.adder_done   <= 1'b1;
      aif.adder_result <= pend;
    end
  end

  always @(negedge clk) begin
    if (aif.adder_start) n_start <= n_start + 1;
    if (aif.adder_shift) n_shift <= n_shift + 1;
    if (done)            n_done  <= n_done + 1;
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] t;
    for (int i = 0; i < 16; i++) t[i*32 +: 32] = $urandom;
    t[W-1:512] = 2'($urandom_range(0, 3));
    return t;
  endfunction

  function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] a, b, m);
    logic [W+1:0] ea, eb, em, x;
    ea = {2'b00, a};
    eb = {2'b00, b};
    em = {2'b00, m};
    case (o)
      2'd0:    x = (ea + eb) % em;
      2'd1:    x = (ea + em - eb) % em;
      2'd2:    x = HALVE ? (ea[0] ? ((ea + em) >> 1) : (ea >> 1)) : '0;
      default: x = '0;
    endcase
    return W'(x);
  endfunction

  function automatic int ref_starts(input logic [1:0] o, input logic [W-1:0] a, b);
    case (o)
      2'd0:    return 2;
      2'd1:    return (a < b) ? 2 : 1;
      2'd2:    return HALVE ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic logic ref_error(input logic [1:0] o);
    return (o == 2'd3) || ((o == 2'd2) && !HALVE);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, b, m);
    @(negedge clk);
    start = 1'b1; op = o; in_a = a; in_b = b; in_m = m;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom_range(0, 3));
    in_a = rand_wide(); in_b = rand_wide(); in_m = rand_wide();
  endtask

  task automatic wait_done(output logic [W-1:0] r, output logic e, output logic b, output bit to);
    int k;
    k = 0; to = 1'b1; r = '0; e = 1'b0; b = 1'b0;
    while (to && (k < 400)) begin
      @(negedge clk);
      k++;
      if (done) begin
        to = 1'b0; r = result; e = error; b = busy;
      end
    end
  endtask

  task automatic exec(input logic [1:0] o, input logic [W-1:0] a, b, m,
                      output logic [W-1:0] r, output logic e, output int starts, output int shifts,
                      output logic busy1, output logic busy_fin, output logic done_after, output bit to);
    int s0, h0;
    @(negedge clk);
    s0 = n_start; h0 = n_shift;
    launch(o, a, b, m);
    busy1 = busy;
    wait_done(r, e, busy_fin, to);
    @(negedge clk);
    done_after = done;
    starts = n_start - s0;
    shifts = n_shift - h0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = '0; in_a = '0; in_b = '0; in_m = '0;
    repeat (3) @(negedge clk);
    n_checks++; if ({busy, done, error} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %b want 000", {busy, done, error}); end
    n_checks++; if ({aif.adder_start, aif.adder_subtract, aif.adder_shift} !== 3'b000) begin n_fail++; $display("FAIL reset_adder_ctl: got %b want 000", {aif.adder_start, aif.adder_subtract, aif.adder_shift}); end
    n_checks++; if (result !== '0) begin n_fail++; $display("FAIL reset_result: got %0h want 0", result); end
    n_checks++; if ({aif.adder_a, aif.adder_b} !== '0) begin n_fail++; $display("FAIL reset_operands: got %0h/%0h want 0", aif.adder_a, aif.adder_b); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    int d_op[5] = '{0, 0, 0, 1, 1};
    int d_a[5]  = '{7, 2, 6, 3, 5};
    int d_b[5]  = '{9, 3, 7, 9, 5};
    int d_r[5]  = '{3, 5, 0, 7, 0};
    int d_s[5]  = '{2, 2, 2, 2, 1};
    logic [W-1:0] r; logic e, b1, bf, da; int st, sh; bit to;
    lazy_cfg = 1'b0; lat_cfg = 3;
    for (int i = 0; i < 5; i++) begin
      exec(2'(d_op[i]), W'(d_a[i]), W'(d_b[i]), W'(13), r, e, st, sh, b1, bf, da, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL dir_timeout[%0d]: got no done want done", i); end
      n_checks++; if (r !== W'(d_r[i])) begin n_fail++; $display("FAIL dir_result[%0d]: got %0h want %0h", i, r, d_r[i]); end
      n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL dir_error[%0d]: got %b want 0", i, e); end
      n_checks++; if (st !== d_s[i]) begin n_fail++; $display("FAIL dir_starts[%0d]: got %0d want %0d", i, st, d_s[i]); end
      n_checks++; if ({b1, bf, da} !== 3'b100) begin n_fail++; $display("FAIL dir_busy_done[%0d]: got %b want 100", i, {b1, bf, da}); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r; logic e, bf; bit to;
    lazy_cfg = 1'b0; lat_cfg = 2;
    launch(2'd0, W'(2), W'(3), W'(13));
    wait_done(r, e, bf, to);
    n_checks++; if (to || (r !== W'(5))) begin n_fail++; $display("FAIL b2b_first: got %0h (timeout %0d) want 5", r, to); end
    start = 1'b1; op = 2'd0; in_a = W'(4); in_b = W'(4); in_m = W'(13);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_fin_start_ignored: busy got %b want 0", busy); end
    launch(2'd0, W'(6), W'(9), W'(13));
    wait_done(r, e, bf, to);
    n_checks++; if (to || (r !== W'(2))) begin n_fail++; $display("FAIL b2b_second: got %0h (timeout %0d) want 2", r, to); end
    launch(2'd1, W'(3), W'(9), W'(13));
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_after_fin_accepted: busy got %b want 1", busy); end
    wait_done(r, e, bf, to);
    n_checks++; if (to || (r !== W'(7))) begin n_fail++; $display("FAIL b2b_third: got %0h (timeout %0d) want 7", r, to); end
  endtask

  task automatic test_busy_start();
    logic [W-1:0] r; logic e, b1, bf, da; int st, sh, d0, s0; bit to;
    lazy_cfg = 1'b1; lat_cfg = 4;
    exec(2'd0, W'(1), W'(2), W'(13), r, e, st, sh, b1, bf, da, to);
    n_checks++; if (to || (r !== W'(3))) begin n_fail++; $display("FAIL lazy_warmup: got %0h want 3", r); end
    d0 = n_done; s0 = n_start;
    launch(2'd0, W'(7), W'(9), W'(13));
    repeat (2) @(negedge clk);
    start = 1'b1; op = 2'd1; in_a = W'(1); in_b = W'(12); in_m = W'(100);
    @(negedge clk);
    start = 1'b0;
    wait_done(r, e, bf, to);
    n_checks++; if (to || (r !== W'(3)) || (e !== 1'b0)) begin n_fail++; $display("FAIL lazy_result: got %0h err %b want 3 err 0", r, e); end
    repeat (8) @(negedge clk);
    n_checks++; if ((n_done - d0) !== 1) begin n_fail++; $display("FAIL lazy_done_count: got %0d want 1", n_done - d0); end
    n_checks++; if ((n_start - s0) !== 2) begin n_fail++; $display("FAIL lazy_adder_starts: got %0d want 2", n_start - s0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lazy_busy_start_ignored: busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] r; logic e, b1, bf, da; int st, sh, s0, d0, k;
    bit to;
    lazy_cfg = 1'b0; lat_cfg = 5;
    s0 = n_start;
    launch(2'd0, W'(7), W'(9), W'(13));
    k = 0;
    while (((n_start - s0) < 2) && (k < 100)) begin @(negedge clk); k++; end
    n_checks++; if ((n_start - s0) !== 2) begin n_fail++; $display("FAIL rmid_reach_wait2: starts got %0d want 2", n_start - s0); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({busy, done, error} !== 3'b000) begin n_fail++; $display("FAIL rmid_async_status: got %b want 000", {busy, done, error}); end
    n_checks++; if ((result !== '0) || ({aif.adder_a, aif.adder_b} !== '0)) begin n_fail++; $display("FAIL rmid_async_data: result %0h a %0h want 0", result, aif.adder_a); end
    d0 = n_done;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++; if (n_done !== d0) begin n_fail++; $display("FAIL rmid_no_done: got %0d pulses want 0", n_done - d0); end
    lat_cfg = 3;
    exec(2'd0, W'(1), W'(1), W'(13), r, e, st, sh, b1, bf, da, to);
    n_checks++; if (to || (r !== W'(2))) begin n_fail++; $display("FAIL rmid_recover: got %0h want 2", r); end
  endtask

  task automatic test_halve();
    logic [W-1:0] r; logic e, b1, bf, da; int st, sh; bit to;
    lazy_cfg = 1'b0; lat_cfg = 3;
`ifdef MOD_HALVE_EN
    exec(2'd2, W'(7), W'(0), W'(13), r, e, st, sh, b1, bf, da, to);
    n_checks++; if (to || (r !== W'(10)) || (e !== 1'b0)) begin n_fail++; $display("FAIL halve_7: got %0h err %b want 10 err 0", r, e); end
    n_checks++; if ((sh !== 1) || (st !== 1)) begin n_fail++; $display("FAIL halve_7_traffic: shifts %0d starts %0d want 1 1", sh, st); end
    exec(2'd2, W'(8), W'(0), W'(13), r, e, st, sh, b1, bf, da, to);
    n_checks++; if (to || (r !== W'(4))) begin n_fail++; $display("FAIL halve_8: got %0h want 4", r); end
`else
    exec(2'd2, W'(7), W'(0), W'(13), r, e, st, sh, b1, bf, da, to);
    n_checks++; if (to || (e !== 1'b1) || (r !== '0)) begin n_fail++; $display("FAIL halve_illegal: got %0h err %b want 0 err 1", r, e); end
    n_checks++; if ((st !== 0) || (sh !== 0)) begin n_fail++; $display("FAIL halve_illegal_traffic: starts %0d shifts %0d want 0 0", st, sh); end
`endif
    exec(2'd3, W'(5), W'(6), W'(13), r, e, st, sh, b1, bf, da, to);
    n_checks++; if (to || (e !== 1'b1) || (r !== '0) || (st !== 0)) begin n_fail++; $display("FAIL op11_illegal: got %0h err %b starts %0d want 0 1 0", r, e, st); end
  endtask

  task automatic test_random();
    logic [W-1:0] r, a, b, m, x; logic [1:0] o; logic e, b1, bf, da; int st, sh, pick; bit to;
    for (int i = 0; i < 40; i++) begin
      pick = $urandom_range(0, 9);
      o = (pick < 4) ? 2'd0 : (pick < 8) ? 2'd1 : (pick == 8) ? 2'd2 : 2'd3;
      m = (rand_wide() >> $urandom_range(1, W - 4)) | W'(1);
      a = rand_wide() % m;
      b = rand_wide() % m;
      lat_cfg  = $urandom_range(2, 6);
      lazy_cfg = 1'($urandom_range(0, 1));
      exp_q.push_back(ref_result(o, a, b, m));
      exec(o, a, b, m, r, e, st, sh, b1, bf, da, to);
      x = exp_q.pop_front();
      n_checks++; if (to) begin n_fail++; $display("FAIL rnd_timeout[%0d]: op %0d no done", i, o); end
      n_checks++; if (r !== x) begin n_fail++; $display("FAIL rnd_result[%0d]: op %0d got %0h want %0h", i, o, r, x); end
      n_checks++; if (e !== ref_error(o)) begin n_fail++; $display("FAIL rnd_error[%0d]: op %0d got %b want %b", i, o, e, ref_error(o)); end
      n_checks++; if (st !== ref_starts(o, a, b)) begin n_fail++; $display("FAIL rnd_starts[%0d]: op %0d got %0d want %0d", i, o, st, ref_starts(o, a, b)); end
      n_checks++; if (sh !== ((o == 2'd2 && HALVE) ? 1 : 0)) begin n_fail++; $display("FAIL rnd_shifts[%0d]: op %0d got %0d", i, o, sh); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_busy_start();
    test_reset_mid();
    test_halve();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
